// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: a five-state FETCH/DECODE/EXEC/MEM/WB sequencer.
// It drives the datapath strobes, captures the opcode in DECODE and counts retired instructions.
module multicycle_control #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    input  logic           halt,
    output logic           pc_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           alu_src,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           branch,
    output logic [1:0]     alu_op,
    output logic [2:0]     state,
    output logic           instr_done,
    output logic           illegal_op,
    output logic [15:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [15:0]    retired_q, retired_d;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                // halt only gates the start of a new instruction
                if (!halt) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        branch     = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (op_q == OP_SW) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = instr_done ? retired_q + 16'd1 : retired_q;

        // Reset silences every strobe immediately, even the FETCH mem_read.
        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            branch     = 1'b0;
            alu_op     = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vectors queued by the driver,
// checked by an independent negedge monitor against the DUT's full output set.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        halt;
    logic        pc_write, ir_write, reg_dst, alu_src, mem_to_reg;
    logic        reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        instr_done, illegal_op;
    logic [15:0] retired;

    multicycle_control #(.OPW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .halt       (halt),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    // Strobe field order: pc_write ir_write reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] PCW  = 9'b100000000;
    localparam logic [8:0] IRW  = 9'b010000000;
    localparam logic [8:0] RDST = 9'b001000000;
    localparam logic [8:0] ASRC = 9'b000100000;
    localparam logic [8:0] M2R  = 9'b000010000;
    localparam logic [8:0] RW   = 9'b000001000;
    localparam logic [8:0] MRD  = 9'b000000100;
    localparam logic [8:0] MWR  = 9'b000000010;
    localparam logic [8:0] BR   = 9'b000000001;
    localparam logic [8:0] FET  = PCW | IRW | MRD;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          step  = 0;
    logic [15:0] exp_ret = 16'd0;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: pops one expected vector per cycle in which the driver queued one
    always @(negedge clk) begin
        logic [31:0] obs, exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = {retired, state, pc_write, ir_write, reg_dst, alu_src, mem_to_reg,
                   reg_write, mem_read, mem_write, branch, alu_op, instr_done, illegal_op};
            total++;
            step++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL step_%0d: got ret=%h st=%0d sb=%b ao=%b done=%b ill=%b, want ret=%h st=%0d sb=%b ao=%b done=%b ill=%b",
                         step, obs[31:16], obs[15:13], obs[12:4], obs[3:2], obs[1], obs[0],
                         exp[31:16], exp[15:13], exp[12:4], exp[3:2], exp[1], exp[0]);
            end
        end
    end

    // driver tasks
    task automatic rst_cyc();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        halt      = $urandom_range(0, 1);
        mem_ready = 1'b1;
        exp_ret   = 16'd0;
        exp_q.push_back({16'd0, 3'd0, NONE, 2'b00, 1'b0, 1'b0});
    endtask

    task automatic cyc(input logic [5:0] op, input logic mr, input logic h,
                       input logic [2:0] st, input logic [8:0] sb,
                       input logic [1:0] ao, input logic done, input logic ill);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        opcode    = op;
        mem_ready = mr;
        halt      = h;
        exp_q.push_back({exp_ret, st, sb, ao, done, ill});
        if (done) exp_ret = exp_ret + 16'd1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b1;
        halt      = 1'b0;

        rst_cyc();
        rst_cyc();

        // R-type; live opcode changes after DECODE must not matter
        cyc(OP_BAD, 1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_R,   1, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_LW,  1, 0, 3'd2, NONE,      2'b10, 0, 0);
        cyc(OP_SW,  1, 0, 3'd4, RW | RDST, 2'b00, 1, 0);

        // lw with three wait cycles in MEM; mem_ready low in DECODE/EXEC/WB is ignored
        cyc(OP_LW,  1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_LW,  0, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_BEQ, 0, 0, 3'd2, ASRC,      2'b00, 0, 0);
        cyc(OP_BEQ, 0, 0, 3'd3, MRD,       2'b00, 0, 0);
        cyc(OP_BEQ, 0, 0, 3'd3, MRD,       2'b00, 0, 0);
        cyc(OP_BEQ, 0, 0, 3'd3, MRD,       2'b00, 0, 0);
        cyc(OP_BEQ, 1, 0, 3'd3, MRD,       2'b00, 0, 0);
        cyc(OP_R,   0, 0, 3'd4, RW | M2R,  2'b00, 1, 0);

        // beq then sw back to back
        cyc(OP_BEQ, 1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_BEQ, 1, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_R,   1, 0, 3'd2, BR,        2'b01, 1, 0);
        cyc(OP_SW,  1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_SW,  1, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_LW,  1, 0, 3'd2, ASRC,      2'b00, 0, 0);
        cyc(OP_R,   1, 0, 3'd3, MWR,       2'b00, 1, 0);

        // FETCH stall without mem_ready, then an illegal opcode
        cyc(OP_BAD, 0, 0, 3'd0, MRD,       2'b00, 0, 0);
        cyc(OP_BAD, 1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_BAD, 1, 0, 3'd1, NONE,      2'b00, 0, 1);
        cyc(OP_BAD, 0, 0, 3'd0, MRD,       2'b00, 0, 0);

        // addi with halt raised in EXEC: it retires, then FETCH idles until halt drops
        cyc(OP_ADDI, 1, 0, 3'd0, FET,      2'b00, 0, 0);
        cyc(OP_ADDI, 1, 0, 3'd1, NONE,     2'b00, 0, 0);
        cyc(OP_ADDI, 1, 1, 3'd2, ASRC,     2'b00, 0, 0);
        cyc(OP_ADDI, 1, 1, 3'd4, RW,       2'b00, 1, 0);
        cyc(OP_ADDI, 1, 1, 3'd0, NONE,     2'b00, 0, 0);
        cyc(OP_ADDI, 0, 1, 3'd0, NONE,     2'b00, 0, 0);
        cyc(OP_R,    1, 0, 3'd0, FET,      2'b00, 0, 0);
        cyc(OP_R,    1, 0, 3'd1, NONE,     2'b00, 0, 0);
        cyc(OP_R,    1, 0, 3'd2, NONE,     2'b10, 0, 0);
        cyc(OP_R,    1, 0, 3'd4, RW | RDST, 2'b00, 1, 0);

        // sw stalled in MEM, then reset asserted asynchronously mid-cycle
        cyc(OP_SW,  1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_SW,  1, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_SW,  0, 0, 3'd2, ASRC,      2'b00, 0, 0);
        cyc(OP_SW,  0, 0, 3'd3, MWR,       2'b00, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_write, state, retired} !== 20'd0) begin
            bad++;
            $display("FAIL async_reset: got mem_write=%b state=%0d retired=%h, want 0 0 0000",
                     mem_write, state, retired);
        end
        rst_cyc();

        // first instruction after reset release (beq, 3 cycles)
        cyc(OP_BEQ, 1, 0, 3'd0, FET,       2'b00, 0, 0);
        cyc(OP_BEQ, 1, 0, 3'd1, NONE,      2'b00, 0, 0);
        cyc(OP_BEQ, 1, 0, 3'd2, BR,        2'b01, 1, 0);
        cyc(OP_BEQ, 0, 1, 3'd0, NONE,      2'b00, 0, 0);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
